// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stall, flush and freeze decisions for the five-stage core.
// Control outputs are combinational from the current inputs. FSM, wait counter, error flag and statistics are registered.
// Optional macro PIPE_FWD_EN: when defined, forwarding is present and only load-use stalls; otherwise any RAW against EXE/MEM stalls.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src_1,
  input  logic [3:0]       src_2,
  input  logic             two_src,
  input  logic             id_uses_src_1,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_front,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze_all,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0]       TIMEOUT_CNT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;

  logic exe_match;
  logic mem_match;
  logic hazard;

  // A source only matches when the ID instruction really reads it.
  assign exe_match = (id_uses_src_1 && (src_1 == exe_dest)) ||
                     (two_src       && (src_2 == exe_dest));
  assign mem_match = (id_uses_src_1 && (src_1 == mem_dest)) ||
                     (two_src       && (src_2 == mem_dest));

`ifdef PIPE_FWD_EN
  // Forwarding covers every producer except a load still in EXE.
  logic unused_fwd;
  assign unused_fwd = mem_match & mem_wb_en;
  assign hazard     = exe_wb_en & exe_mem_r_en & exe_match;
`else
  // No forwarding: any writer in EXE or MEM blocks a dependent ID instruction.
  assign hazard = (exe_wb_en & exe_match) | (mem_wb_en & mem_match);
`endif

  // The data-memory port holds the whole pipeline while an access is outstanding.
  assign freeze_all = mem_req & ~mem_ready;

  // Front-end controls by priority: global freeze defers everything, a taken branch discards ID, then hazards.
  always_comb begin
    freeze_front = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    if (freeze_all) begin
      freeze_front = 1'b0;
    end else if (branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hazard) begin
      freeze_front = 1'b1;
      flush_id_ex  = 1'b1;
    end
  end

  // Next state and wait counter; the FSM keeps waiting even after a timeout.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        wait_cnt_nxt = 8'd0;
        if (mem_req && !mem_ready) begin
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (wait_cnt != 8'hFF) begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
        if (mem_ready) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout_err <= 1'b0;
    end else if ((state == MEM_WAIT) && (wait_cnt == TIMEOUT_CNT)) begin
      mem_timeout_err <= 1'b1;
    end
  end

  // Saturating bring-up statistics; a branch seen while frozen is not counted until it is acted on.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if ((freeze_front || freeze_all) && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (branch_taken && !freeze_all && (flush_events != CNT_MAX)) begin
        flush_events <= flush_events + 1'b1;
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage ARM core. It decides, every cycle, whether the front end advances, holds or is flushed. It drives the `flush` input of the ID/EX stage register (the bubble inserter) and the freeze/flush controls of PC and IF/ID, and it stalls the whole pipeline while the data-memory port waits. It also keeps saturating stall/flush statistics for bring-up.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: wait cycles in `MEM_WAIT` before `mem_timeout_err` sets.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `src_1`  in  4  Rn index of the instruction in ID.
- `src_2`  in  4  Rm/Rd-store index of the instruction in ID.
- `two_src`  in  1  ID instruction reads `src_2`.
- `id_uses_src_1`  in  1  ID instruction reads `src_1` (low for MOV/MVN/B).
- `exe_dest`  in  4  destination register in EXE.
- `exe_wb_en`  in  1  EXE instruction writes back.
- `exe_mem_r_en`  in  1  EXE instruction is a load.
- `mem_dest`  in  4  destination register in MEM.
- `mem_wb_en`  in  1  MEM instruction writes back.
- `branch_taken`  in  1  taken branch resolved in EXE.
- `mem_req`  in  1  MEM stage has an active load or store.
- `mem_ready`  in  1  memory port completes the access this cycle.
- `freeze_front`  out  1  hold PC and IF/ID.
- `flush_if_id`  out  1  bubble IF/ID.
- `flush_id_ex`  out  1  bubble ID/EX; drives the ID/EX register `flush`.
- `freeze_all`  out  1  hold every pipeline register, including ID/EX, EX/MEM and MEM/WB.
- `mem_timeout_err`  out  1  sticky memory timeout flag.
- `stall_cycles`  out  `CNT_W`  count of cycles with `freeze_front` or `freeze_all` high.
- `flush_events`  out  `CNT_W`  count of cycles with `branch_taken` acted on.

## Operation
- States: `RUN` and `MEM_WAIT`. There is also an internal `wait_cnt` (8 bits, saturating).
- `RUN` → `MEM_WAIT` when `mem_req & ~mem_ready`.
- `MEM_WAIT` → `RUN` when `mem_ready`.
- `wait_cnt` clears in `RUN` and increments in `MEM_WAIT`.
- `wait_cnt == MEM_TIMEOUT` in `MEM_WAIT` sets `mem_timeout_err`. It stays set until `rst`. The FSM keeps waiting.
- `freeze_all = mem_req & ~mem_ready`, in either state.
- A source matches when its index equals the dest and it is actually used: `src_1` with `id_uses_src_1`, `src_2` with `two_src`.
- `hazard` with `PIPE_FWD_EN`: `exe_wb_en & exe_mem_r_en` & (src match on `exe_dest`).
- `hazard` without `PIPE_FWD_EN`: (`exe_wb_en` & match `exe_dest`) | (`mem_wb_en` & match `mem_dest`).
- Output priority is highest first:
  1. `freeze_all`: all other controls 0, because a branch or hazard is deferred while frozen.
  2. `branch_taken`: `flush_if_id=1`, `flush_id_ex=1`, `freeze_front=0`. The hazard is ignored because the ID instruction is discarded.
  3. `hazard`: `freeze_front=1`, `flush_id_ex=1`.
  4. Otherwise all 0.
- Counters saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from the current inputs. Only the FSM, `wait_cnt`, the error flag and the counters are registered.
- Reset values: state `RUN`, `wait_cnt` 0, `mem_timeout_err` 0, `stall_cycles` 0, `flush_events` 0. Combinational outputs follow their inputs during reset.
- Load-use with forwarding costs 1 bubble. Without forwarding a RAW costs up to 2 bubbles: one while the producer is in EXE, one while it is in MEM.
- `mem_ready` high in the same cycle as `mem_req` gives zero stall, and the FSM never leaves `RUN`.
- `rst` during `MEM_WAIT` returns to `RUN` on the next edge and clears the error flag and counters.
- `branch_taken` together with `freeze_all`: no flush that cycle and no `flush_events` increment. The flush is issued in the first unfrozen cycle.

## Configuration
- `PIPE_FWD_EN` defined: the forwarding unit is present, so only a load in EXE whose dest matches a used source stalls.
- `PIPE_FWD_EN` undefined: any used-source match against a writing EXE or MEM instruction stalls.
- Ports are identical in both builds.

## Test plan
- Load-use: `exe_mem_r_en=1`, `exe_wb_en=1`, `exe_dest=3`, `src_1=3`, `id_uses_src_1=1` → `freeze_front=1` and `flush_id_ex=1` for exactly 1 cycle; `stall_cycles` increments by 1.
- Non-forwarding RAW (build without `PIPE_FWD_EN`): ADD writes r5, next instruction reads r5 as `src_2` with `two_src=1` → 2 consecutive stall cycles. With the macro defined → 0 stall cycles.
- Branch priority: `branch_taken=1` together with a matching hazard → `flush_if_id=1`, `flush_id_ex=1`, `freeze_front=0`; `flush_events` becomes 1.
- Memory wait: `mem_req=1`, `mem_ready` low for 4 cycles then high → `freeze_all` high for exactly 4 cycles. The FSM is in `MEM_WAIT` for 4 edges, then returns to `RUN`.
- Timeout: `MEM_TIMEOUT=8` with `mem_ready` held low → `mem_timeout_err` rises after 8 cycles in `MEM_WAIT` and stays high after `mem_ready`. Asserting `rst` for 1 cycle clears it.
- Saturation: `CNT_W=4`, 20 stall cycles → `stall_cycles=15`.
